// File: rtl/cv32e40p_if_id_pipe_nmr_pkg.sv
// Shared types for the N-modular-redundant IF/ID pipeline register.
// The payload struct is declared MSB first so that instr_valid lands on bit 0.
package cv32e40p_if_id_pipe_nmr_pkg;

    localparam int unsigned IF_ID_PAYLOAD_W = 68;

    typedef struct packed {
        logic [31:0] pc;
        logic        fetch_failed;
        logic        illegal_c_insn;
        logic        is_compressed;
        logic [31:0] instr_rdata;
        logic        instr_valid;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        REP_OK,
        REP_SUSPECT,
        REP_FAILED
    } replica_state_e;

    function automatic if_id_payload_t payload_clear(if_id_payload_t p, logic fetch_failed);
        if_id_payload_t r;
        r              = p;
        r.instr_valid  = 1'b0;
        r.fetch_failed = fetch_failed;
        return r;
    endfunction

    // Indices beyond the payload produce an empty mask.
    function automatic logic [IF_ID_PAYLOAD_W-1:0] payload_bit_mask(logic [6:0] idx);
        logic [IF_ID_PAYLOAD_W-1:0] m;
        m = '0;
        if (32'(idx) < IF_ID_PAYLOAD_W) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cv32e40p_if_id_pipe_nmr_if.sv
// IF-to-ID handshake and payload bundle; master is the IF side, slave is the pipe register.
interface cv32e40p_if_id_pipe_nmr_if;

    logic        if_valid_i;
    logic        instr_valid_i;
    logic [31:0] instr_rdata_i;
    logic        is_compressed_i;
    logic        illegal_c_insn_i;
    logic [31:0] pc_i;
    logic        clear_instr_valid_i;
    logic        fetch_failed_i;

    logic        instr_valid_id_o;
    logic [31:0] instr_rdata_id_o;
    logic        is_compressed_id_o;
    logic        illegal_c_insn_id_o;
    logic [31:0] pc_id_o;
    logic        is_fetch_failed_o;

    modport master (
        output if_valid_i, instr_valid_i, instr_rdata_i, is_compressed_i, illegal_c_insn_i,
               pc_i, clear_instr_valid_i, fetch_failed_i,
        input  instr_valid_id_o, instr_rdata_id_o, is_compressed_id_o, illegal_c_insn_id_o,
               pc_id_o, is_fetch_failed_o
    );

    modport slave (
        input  if_valid_i, instr_valid_i, instr_rdata_i, is_compressed_i, illegal_c_insn_i,
               pc_i, clear_instr_valid_i, fetch_failed_i,
        output instr_valid_id_o, instr_rdata_id_o, is_compressed_id_o, illegal_c_insn_id_o,
               pc_id_o, is_fetch_failed_o
    );

endinterface

// File: rtl/cv32e40p_if_id_pipe_nmr_voter.sv
// Combinational bitwise majority voter over the active replicas.
// Ties resolve to the lowest-index active replica and raise tie_o.
module cv32e40p_nmr_voter #(
    parameter int unsigned Width       = 68,
    parameter int unsigned NumReplicas = 3
) (
    input  logic [NumReplicas-1:0][Width-1:0] words_i,
    input  logic [NumReplicas-1:0]            active_i,
    output logic [Width-1:0]                  voted_o,
    output logic [NumReplicas-1:0]            mismatch_o,
    output logic                              tie_o
);

    // One spare bit so that twice the ones count never overflows.
    localparam int unsigned CntW = $clog2(NumReplicas + 1) + 1;

    logic [CntW-1:0]  act_cnt;
    logic [CntW-1:0]  ones;
    logic [Width-1:0] low_word;

    always_comb begin
        act_cnt  = '0;
        low_word = words_i[0];
        for (int i = NumReplicas - 1; i >= 0; i--) begin
            act_cnt = act_cnt + CntW'(active_i[i]);
            if (active_i[i]) begin
                low_word = words_i[i];
            end
        end
    end

    always_comb begin
        voted_o = '0;
        tie_o   = 1'b0;
        ones    = '0;
        for (int b = 0; b < int'(Width); b++) begin
            ones = '0;
            for (int i = 0; i < int'(NumReplicas); i++) begin
                ones = ones + CntW'(active_i[i] & words_i[i][b]);
            end
            if ((ones << 1) > act_cnt) begin
                voted_o[b] = 1'b1;
            end else if ((ones << 1) == act_cnt) begin
                voted_o[b] = low_word[b];
                tie_o      = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumReplicas); i++) begin
            mismatch_o[i] = active_i[i] && (words_i[i] != voted_o);
        end
    end

endmodule

// File: rtl/cv32e40p_if_id_pipe_nmr.sv
// N-modular-redundant IF/ID pipeline register with voting, scrubbing and replica retirement.
// Each replica carries a small fault FSM; stuck replicas are retired while two or more remain.
module cv32e40p_if_id_pipe_nmr
    import cv32e40p_if_id_pipe_nmr_pkg::*;
#(
    parameter int unsigned NUM_REPLICAS    = 3,
    parameter bit          SCRUB_EN        = 1'b1,
    parameter int unsigned FAULT_THRESHOLD = 3,
    parameter int unsigned ERR_CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cv32e40p_if_id_pipe_nmr_if.slave    bus,
    input  logic                        fault_inj_en_i,
    input  logic [NUM_REPLICAS-1:0]     fault_inj_mask_i,
    input  logic [6:0]                  fault_inj_bit_i,
    output logic                        err_corrected_o,
    output logic                        err_uncorrectable_o,
    output logic [NUM_REPLICAS-1:0]     replica_failed_o,
    output logic [ERR_CNT_W-1:0]        err_count_o
);

    localparam bit          Voting  = (NUM_REPLICAS > 1);
    localparam logic [3:0]  Thresh4 = 4'(FAULT_THRESHOLD);
    localparam logic [4:0]  Thresh5 = 5'(FAULT_THRESHOLD);

    if_id_payload_t [NUM_REPLICAS-1:0] replica_d, replica_q;
    if_id_payload_t                    voted;
    if_id_payload_t                    load_word;
    logic [IF_ID_PAYLOAD_W-1:0]        inj_vec;

    logic [NUM_REPLICAS-1:0] active;
    logic [NUM_REPLICAS-1:0] mismatch_raw, mismatch;
    logic                    tie_raw, tie;
    logic [3:0]              act_cnt;
    logic [3:0]              remaining;
    logic                    load_en;

    replica_state_e state_d [NUM_REPLICAS];
    replica_state_e state_q [NUM_REPLICAS];
    logic [3:0]     cnt_d   [NUM_REPLICAS];
    logic [3:0]     cnt_q   [NUM_REPLICAS];
    logic [4:0]     next_cnt[NUM_REPLICAS];

    logic                 err_corr_d, err_corr_q;
    logic                 err_unc_d, err_unc_q;
    logic [ERR_CNT_W-1:0] err_count_d, err_count_q;

    cv32e40p_nmr_voter #(
        .Width       (IF_ID_PAYLOAD_W),
        .NumReplicas (NUM_REPLICAS)
    ) u_voter (
        .words_i    (replica_q),
        .active_i   (active),
        .voted_o    (voted),
        .mismatch_o (mismatch_raw),
        .tie_o      (tie_raw)
    );

    assign mismatch = Voting ? mismatch_raw : '0;
    assign tie      = Voting ? tie_raw : 1'b0;
    assign load_en  = bus.if_valid_i & bus.instr_valid_i;
    assign inj_vec  = payload_bit_mask(fault_inj_bit_i);

    always_comb begin
        act_cnt = '0;
        for (int i = 0; i < int'(NUM_REPLICAS); i++) begin
            replica_failed_o[i] = (state_q[i] == REP_FAILED);
            active[i]           = (state_q[i] != REP_FAILED);
            act_cnt             = act_cnt + 4'(active[i]);
        end
    end

    always_comb begin
        load_word                = '0;
        load_word.instr_valid    = 1'b1;
        load_word.instr_rdata    = bus.instr_rdata_i;
        load_word.is_compressed  = bus.is_compressed_i;
        load_word.illegal_c_insn = bus.illegal_c_insn_i;
        load_word.pc             = bus.pc_i;
    end

    // Retired replicas still follow load/clear so that a future reset restores them cleanly.
    always_comb begin
        for (int i = 0; i < int'(NUM_REPLICAS); i++) begin
            if (load_en) begin
                replica_d[i] = load_word;
            end else if (bus.clear_instr_valid_i) begin
                replica_d[i] = payload_clear(replica_q[i], bus.fetch_failed_i);
            end else if (SCRUB_EN && mismatch[i]) begin
                replica_d[i] = voted;
            end else begin
                replica_d[i] = replica_q[i];
            end
            if (fault_inj_en_i && fault_inj_mask_i[i]) begin
                replica_d[i] = if_id_payload_t'(replica_d[i] ^ inj_vec);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REPLICAS); i++) begin
            next_cnt[i] = (state_q[i] == REP_SUSPECT) ? ({1'b0, cnt_q[i]} + 5'd1) : 5'd1;
        end
    end

    // Retirements are granted in index order while at least two replicas would remain.
    always_comb begin
        remaining = act_cnt;
        for (int i = 0; i < int'(NUM_REPLICAS); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (Voting && state_q[i] != REP_FAILED) begin
                if (!mismatch[i]) begin
                    state_d[i] = REP_OK;
                    cnt_d[i]   = 4'd0;
                end else if (next_cnt[i] >= Thresh5) begin
                    cnt_d[i] = Thresh4;
                    if (remaining > 4'd2) begin
                        state_d[i] = REP_FAILED;
                        remaining  = remaining - 4'd1;
                    end else begin
                        state_d[i] = REP_SUSPECT;
                    end
                end else begin
                    state_d[i] = REP_SUSPECT;
                    cnt_d[i]   = next_cnt[i][3:0];
                end
            end
        end
    end

    always_comb begin
        err_corr_d  = (|mismatch) & ~tie;
        err_unc_d   = tie;
        err_count_d = err_count_q;
        if (err_corr_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            replica_q   <= '0;
            err_corr_q  <= 1'b0;
            err_unc_q   <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < int'(NUM_REPLICAS); i++) begin
                state_q[i] <= REP_OK;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            replica_q   <= replica_d;
            err_corr_q  <= err_corr_d;
            err_unc_q   <= err_unc_d;
            err_count_q <= err_count_d;
            for (int i = 0; i < int'(NUM_REPLICAS); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.instr_valid_id_o    = voted.instr_valid;
    assign bus.instr_rdata_id_o    = voted.instr_rdata;
    assign bus.is_compressed_id_o  = voted.is_compressed;
    assign bus.illegal_c_insn_id_o = voted.illegal_c_insn;
    assign bus.pc_id_o             = voted.pc;
    assign bus.is_fetch_failed_o   = voted.fetch_failed;

    assign err_corrected_o     = err_corr_q;
    assign err_uncorrectable_o = err_unc_q;
    assign err_count_o         = err_count_q;

endmodule

// File: tb/tb_cv32e40p_if_id_pipe_nmr.sv
// Directed bench for the triple-redundant IF/ID register: load, clear, scrub, retire, tie, reset.
module tb_cv32e40p_if_id_pipe_nmr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fault_inj_en;
    logic [2:0]  fault_inj_mask;
    logic [6:0]  fault_inj_bit;
    logic        err_corr;
    logic        err_unc;
    logic [2:0]  rep_failed;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    cv32e40p_if_id_pipe_nmr_if bus ();

    cv32e40p_if_id_pipe_nmr #(
        .NUM_REPLICAS    (3),
        .SCRUB_EN        (1'b1),
        .FAULT_THRESHOLD (3),
        .ERR_CNT_W       (16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .fault_inj_en_i      (fault_inj_en),
        .fault_inj_mask_i    (fault_inj_mask),
        .fault_inj_bit_i     (fault_inj_bit),
        .err_corrected_o     (err_corr),
        .err_uncorrectable_o (err_unc),
        .replica_failed_o    (rep_failed),
        .err_count_o         (err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.instr_valid_id_o !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %0b want 0", bus.instr_valid_id_o); end
        checks++; if (bus.instr_rdata_id_o !== 32'h0) begin errors++;
            $display("FAIL reset_rdata got %h want 0", bus.instr_rdata_id_o); end
        checks++; if (bus.pc_id_o !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want 0", bus.pc_id_o); end
        checks++; if ({err_corr, err_unc} !== 2'b00) begin errors++;
            $display("FAIL reset_err got %b want 00", {err_corr, err_unc}); end
        checks++; if (rep_failed !== 3'b000 || err_count !== 16'd0) begin errors++;
            $display("FAIL reset_status got failed=%b cnt=%0d want 000/0", rep_failed, err_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        bus.if_valid_i    = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_rdata_i = 32'h00A00093;
        bus.pc_i          = 32'h80;
        step();
        checks++; if (bus.instr_valid_id_o !== 1'b1) begin errors++;
            $display("FAIL load_valid got %0b want 1", bus.instr_valid_id_o); end
        checks++; if (bus.instr_rdata_id_o !== 32'h00A00093) begin errors++;
            $display("FAIL load_rdata got %h want 00a00093", bus.instr_rdata_id_o); end
        checks++; if (bus.pc_id_o !== 32'h80 || bus.is_fetch_failed_o !== 1'b0) begin errors++;
            $display("FAIL load_pc got %h/%0b want 80/0", bus.pc_id_o, bus.is_fetch_failed_o); end
        checks++; if ({err_corr, err_unc} !== 2'b00) begin errors++;
            $display("FAIL load_err got %b want 00", {err_corr, err_unc}); end
        // if_valid without instr_valid must not load
        bus.instr_valid_i = 1'b0;
        bus.instr_rdata_i = 32'hFFFFFFFF;
        step();
        checks++; if (bus.instr_rdata_id_o !== 32'h00A00093) begin errors++;
            $display("FAIL load_gated got %h want 00a00093", bus.instr_rdata_id_o); end
        bus.if_valid_i = 1'b0;
    endtask

    task automatic test_clear();
        bus.clear_instr_valid_i = 1'b1;
        bus.fetch_failed_i      = 1'b1;
        step();
        bus.clear_instr_valid_i = 1'b0;
        bus.fetch_failed_i      = 1'b0;
        checks++; if (bus.instr_valid_id_o !== 1'b0 || bus.is_fetch_failed_o !== 1'b1) begin
            errors++; $display("FAIL clear_flags got %0b/%0b want 0/1",
                               bus.instr_valid_id_o, bus.is_fetch_failed_o); end
        checks++; if (bus.instr_rdata_id_o !== 32'h00A00093 || bus.pc_id_o !== 32'h80) begin
            errors++; $display("FAIL clear_hold got %h/%h want 00a00093/80",
                               bus.instr_rdata_id_o, bus.pc_id_o); end
    endtask

    task automatic test_single_fault();
        fault_inj_en = 1'b1; fault_inj_mask = 3'b010; fault_inj_bit = 7'd5;
        step();
        fault_inj_en = 1'b0;
        checks++; if (bus.instr_rdata_id_o !== 32'h00A00093 || err_corr !== 1'b0) begin errors++;
            $display("FAIL single_vote got %h/%0b want 00a00093/0", bus.instr_rdata_id_o, err_corr); end
        step();
        checks++; if (err_corr !== 1'b1 || err_count !== 16'd1) begin errors++;
            $display("FAIL single_pulse got %0b/%0d want 1/1", err_corr, err_count); end
        step();
        checks++; if (err_corr !== 1'b0 || err_count !== 16'd1 || err_unc !== 1'b0) begin errors++;
            $display("FAIL single_scrub got %0b/%0d/%0b want 0/1/0", err_corr, err_count, err_unc); end
    endtask

    task automatic test_load_over_fault();
        fault_inj_en = 1'b1; fault_inj_mask = 3'b001; fault_inj_bit = 7'd5;
        step();
        fault_inj_en          = 1'b0;
        bus.if_valid_i        = 1'b1;
        bus.instr_valid_i     = 1'b1;
        bus.instr_rdata_i     = 32'h12345678;
        bus.pc_i              = 32'h100;
        bus.is_compressed_i   = 1'b1;
        checks++; if (bus.instr_rdata_id_o !== 32'h00A00093) begin errors++;
            $display("FAIL lof_vote got %h want 00a00093", bus.instr_rdata_id_o); end
        step();
        bus.if_valid_i      = 1'b0;
        bus.instr_valid_i   = 1'b0;
        bus.is_compressed_i = 1'b0;
        checks++; if (bus.instr_rdata_id_o !== 32'h12345678 || bus.pc_id_o !== 32'h100) begin
            errors++; $display("FAIL lof_data got %h/%h want 12345678/100",
                               bus.instr_rdata_id_o, bus.pc_id_o); end
        checks++; if ({bus.instr_valid_id_o, bus.is_compressed_id_o, bus.is_fetch_failed_o}
                      !== 3'b110) begin errors++;
            $display("FAIL lof_flags got %b want 110", {bus.instr_valid_id_o,
                     bus.is_compressed_id_o, bus.is_fetch_failed_o}); end
        checks++; if (err_corr !== 1'b1 || err_count !== 16'd2) begin errors++;
            $display("FAIL lof_pulse got %0b/%0d want 1/2", err_corr, err_count); end
        step();
        checks++; if (err_corr !== 1'b0 || err_count !== 16'd2) begin errors++;
            $display("FAIL lof_clean got %0b/%0d want 0/2", err_corr, err_count); end
    endtask

    task automatic test_stuck_fault();
        fault_inj_en = 1'b1; fault_inj_mask = 3'b100; fault_inj_bit = 7'd40;
        step();
        step();
        step();
        checks++; if (rep_failed !== 3'b000) begin errors++;
            $display("FAIL stuck_early got %b want 000", rep_failed); end
        step();
        fault_inj_en = 1'b0;
        checks++; if (rep_failed !== 3'b100 || err_count !== 16'd5) begin errors++;
            $display("FAIL stuck_retire got %b/%0d want 100/5", rep_failed, err_count); end
        step();
        checks++; if (err_corr !== 1'b0 || bus.pc_id_o !== 32'h100) begin errors++;
            $display("FAIL stuck_vote got %0b/%h want 0/100", err_corr, bus.pc_id_o); end
    endtask

    task automatic test_tie();
        fault_inj_en = 1'b1; fault_inj_mask = 3'b001; fault_inj_bit = 7'd0;
        step();
        fault_inj_en = 1'b0;
        checks++; if (bus.instr_valid_id_o !== 1'b0 || err_unc !== 1'b0) begin errors++;
            $display("FAIL tie_lowest got %0b/%0b want 0/0", bus.instr_valid_id_o, err_unc); end
        step();
        checks++; if (err_unc !== 1'b1 || err_corr !== 1'b0 || err_count !== 16'd5) begin errors++;
            $display("FAIL tie_pulse got %0b/%0b/%0d want 1/0/5", err_unc, err_corr, err_count); end
        // Sustained ties keep one replica mismatching, but two must stay active.
        fault_inj_en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        fault_inj_en = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++; if (rep_failed !== 3'b100) begin errors++;
            $display("FAIL tie_no_retire got %b want 100", rep_failed); end
        checks++; if (bus.instr_valid_id_o !== 1'b0 || err_unc !== 1'b0 || err_count !== 16'd5) begin
            errors++; $display("FAIL tie_settle got %0b/%0b/%0d want 0/0/5",
                               bus.instr_valid_id_o, err_unc, err_count); end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (rep_failed !== 3'b000 || err_count !== 16'd0) begin errors++;
            $display("FAIL mreset_status got %b/%0d want 000/0", rep_failed, err_count); end
        checks++; if (bus.instr_valid_id_o !== 1'b0 || bus.instr_rdata_id_o !== 32'h0) begin
            errors++; $display("FAIL mreset_data got %0b/%h want 0/0",
                               bus.instr_valid_id_o, bus.instr_rdata_id_o); end
        bus.if_valid_i    = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_rdata_i = 32'hDEADBEEF;
        bus.pc_i          = 32'h200;
        step();
        bus.if_valid_i    = 1'b0;
        bus.instr_valid_i = 1'b0;
        checks++; if (bus.instr_rdata_id_o !== 32'hDEADBEEF || bus.pc_id_o !== 32'h200) begin
            errors++; $display("FAIL mreset_load got %h/%h want deadbeef/200",
                               bus.instr_rdata_id_o, bus.pc_id_o); end
        fault_inj_en = 1'b1; fault_inj_mask = 3'b100; fault_inj_bit = 7'd40;
        step();
        fault_inj_en = 1'b0;
        step();
        checks++; if (err_corr !== 1'b1 || err_count !== 16'd1 || rep_failed !== 3'b000) begin
            errors++; $display("FAIL mreset_revive got %0b/%0d/%b want 1/1/000",
                               err_corr, err_count, rep_failed); end
    endtask

    initial begin
        rst_n                   = 1'b0;
        fault_inj_en            = 1'b0;
        fault_inj_mask          = 3'b000;
        fault_inj_bit           = 7'd0;
        bus.if_valid_i          = 1'b0;
        bus.instr_valid_i       = 1'b0;
        bus.instr_rdata_i       = 32'h0;
        bus.is_compressed_i     = 1'b0;
        bus.illegal_c_insn_i    = 1'b0;
        bus.pc_i                = 32'h0;
        bus.clear_instr_valid_i = 1'b0;
        bus.fetch_failed_i      = 1'b0;

        test_reset();
        test_load();
        test_clear();
        test_single_fault();
        test_load_over_fault();
        test_stuck_fault();
        test_tie();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
